player_motion: RTL



---
 rtl/player_pkg.sv | 23 ++
 rtl/player_motion_if.sv | 29 ++
 rtl/sat_step_counter.sv | 53 +++++
 rtl/player_motion.sv | 127 ++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared definitions for the player position controller.
//   state_t      : dive FSM encoding (2'd3 is illegal, recovers to GROUND)
//   DEF_*        : default playfield geometry, step sizes and air supply
package player_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    DIVE   = 2'd1,
    RISE   = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_X_MIN    = 8;
  localparam int DEF_X_MAX    = 615;
  localparam int DEF_START_X  = 315;
  localparam int DEF_Y_GROUND = 344;
  localparam int DEF_Y_MAX    = 456;
  localparam int DEF_STEP_X   = 1;
  localparam int DEF_STEP_Y   = 1;
  localparam int DEF_AIR_MAX  = 64;
  localparam int DEF_AIR_W    = 8;

endpackage

// File: rtl/player_motion_if.sv
// Bundle between the button/frame-tick side and the renderer/collision side.
//   master : drives restart/frame/game/buttons, observes position and status
//   slave  : the motion controller
interface player_motion_if #(
  parameter int WIDTH = 16,
  parameter int AIR_W = 8
);
  logic             restart;
  logic             frame;
  logic             game;
  logic             btnL;
  logic             btnR;
  logic             btnD;
  logic [WIDTH-1:0] px;
  logic [WIDTH-1:0] py;
  logic [1:0]       pstate;
  logic [AIR_W-1:0] air;
  logic             submerged;

  modport master (
    output restart, frame, game, btnL, btnR, btnD,
    input  px, py, pstate, air, submerged
  );

  modport slave (
    input  restart, frame, game, btnL, btnR, btnD,
    output px, py, pstate, air, submerged
  );
endinterface

// File: rtl/sat_step_counter.sv
// Saturating up/down counter with a fixed step.
//   clk, rst_n : clock, async active-low reset (to RST_VAL)
//   load       : synchronous reload to RST_VAL, wins over en
//   en         : step qualifier
//   inc, dec   : step direction; both or neither holds the value
//   q          : registered count, always inside [MIN, MAX]
module sat_step_counter #(
  parameter int unsigned W       = 16,
  parameter int unsigned MIN     = 0,
  parameter int unsigned MAX     = 255,
  parameter int unsigned STEP    = 1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] q
);

  // One extra bit so the step can never wrap before it is clamped.
  localparam logic [W:0] MIN_E  = (W+1)'(MIN);
  localparam logic [W:0] MAX_E  = (W+1)'(MAX);
  localparam logic [W:0] STEP_E = (W+1)'(STEP);
  localparam logic [W:0] RST_E  = (W+1)'(RST_VAL);

  logic [W-1:0] q_q, q_d;
  logic [W:0]   up, dn;

  always_comb begin
    up  = {1'b0, q_q} + STEP_E;
    dn  = {1'b0, q_q} - STEP_E;
    q_d = q_q;
    if (load) begin
      q_d = RST_E[W-1:0];
    end else if (en && inc && !dec) begin
      q_d = (up > MAX_E) ? MAX_E[W-1:0] : up[W-1:0];
    end else if (en && dec && !inc) begin
      // dn[W] set means the subtraction borrowed below zero.
      q_d = (dn[W] || (dn < MIN_E)) ? MIN_E[W-1:0] : dn[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= RST_E[W-1:0];
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/player_motion.sv
// Player position controller: horizontal walk on the surface, dive with a
// limited air supply, automatic rise back to the surface.
//   clk, resetp_n : clock, async active-low reset
//   bus (slave)   : restart/frame/game/btnL/btnR/btnD in;
//                   px/py/pstate/air/submerged out (all registered)
//
// state  | meaning
// GROUND | on the surface; walk left/right, air refills
// DIVE   | descending while btnD held and air remains; px frozen
// RISE   | ascending to the surface; px frozen, btnD ignored
module player_motion
  import player_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int X_MIN    = DEF_X_MIN,
  parameter int X_MAX    = DEF_X_MAX,
  parameter int START_X  = DEF_START_X,
  parameter int Y_GROUND = DEF_Y_GROUND,
  parameter int Y_MAX    = DEF_Y_MAX,
  parameter int STEP_X   = DEF_STEP_X,
  parameter int STEP_Y   = DEF_STEP_Y,
  parameter int AIR_MAX  = DEF_AIR_MAX,
  parameter int AIR_W    = DEF_AIR_W
) (
  input logic             clk,
  input logic             resetp_n,
  player_motion_if.slave  bus
);

  localparam logic [WIDTH:0] RISE_END = (WIDTH+1)'(Y_GROUND + STEP_Y);

  state_t           state_q, state_d;
  logic             submerged_q, submerged_d;
  logic [WIDTH-1:0] px_q, py_q;
  logic [AIR_W-1:0] air_q;
  logic             en, air_ok, rise_done;
  logic             px_inc, px_dec, py_inc, py_dec, air_inc, air_dec;

  assign en        = bus.frame & ~bus.game;
  assign air_ok    = (air_q != '0);
  // The next upward step lands on (or clamps to) the surface row.
  assign rise_done = ({1'b0, py_q} <= RISE_END);

  always_comb begin
    state_d = state_q;
    px_inc  = 1'b0;
    px_dec  = 1'b0;
    py_inc  = 1'b0;
    py_dec  = 1'b0;
    air_inc = 1'b0;
    air_dec = 1'b0;
    case (state_q)
      GROUND: begin
        px_inc = bus.btnR & ~bus.btnL;
        px_dec = bus.btnL & ~bus.btnR;
        if (bus.btnD && air_ok) begin
          state_d = DIVE;
          py_inc  = 1'b1;
          air_dec = 1'b1;
        end else begin
          air_inc = 1'b1;
        end
      end
      DIVE: begin
        if (bus.btnD && air_ok) begin
          py_inc  = 1'b1;
          air_dec = 1'b1;
        end else begin
          state_d = RISE;
        end
      end
      RISE: begin
        py_dec = 1'b1;
        if (rise_done) state_d = GROUND;
      end
      default: state_d = GROUND;
    endcase
  end

  // submerged follows py's next value: any downward step leaves the surface,
  // an upward step stays below only if it does not reach the surface row.
  always_comb begin
    submerged_d = submerged_q;
    if (bus.restart)       submerged_d = 1'b0;
    else if (en && py_inc) submerged_d = 1'b1;
    else if (en && py_dec) submerged_d = ~rise_done;
  end

  always_ff @(posedge clk or negedge resetp_n) begin
    if (!resetp_n) begin
      state_q     <= GROUND;
      submerged_q <= 1'b0;
    end else begin
      submerged_q <= submerged_d;
      if (bus.restart) state_q <= GROUND;
      else if (en)     state_q <= state_d;
    end
  end

  sat_step_counter #(
    .W(WIDTH), .MIN(X_MIN), .MAX(X_MAX), .STEP(STEP_X), .RST_VAL(START_X)
  ) u_px (
    .clk(clk), .rst_n(resetp_n), .load(bus.restart), .en(en),
    .inc(px_inc), .dec(px_dec), .q(px_q)
  );

  sat_step_counter #(
    .W(WIDTH), .MIN(Y_GROUND), .MAX(Y_MAX), .STEP(STEP_Y), .RST_VAL(Y_GROUND)
  ) u_py (
    .clk(clk), .rst_n(resetp_n), .load(bus.restart), .en(en),
    .inc(py_inc), .dec(py_dec), .q(py_q)
  );

  sat_step_counter #(
    .W(AIR_W), .MIN(0), .MAX(AIR_MAX), .STEP(1), .RST_VAL(AIR_MAX)
  ) u_air (
    .clk(clk), .rst_n(resetp_n), .load(bus.restart), .en(en),
    .inc(air_inc), .dec(air_dec), .q(air_q)
  );

  assign bus.px        = px_q;
  assign bus.py        = py_q;
  assign bus.pstate    = state_q;
  assign bus.air       = air_q;
  assign bus.submerged = submerged_q;

endmodule
